// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, queue entry type and PC alignment helper for the fetch stage
package fetch_pkg;
   localparam int          DEF_XLEN     = 32;
   localparam int          DEF_ILEN     = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0;
   localparam int          DEF_PC_STEP  = 4;

   typedef struct packed {
      logic [DEF_XLEN-1:0] pc;
      logic [DEF_ILEN-1:0] inst;
   } fetch_entry_t;

   // clears the low log2(step) bits; step is a power of two
   function automatic logic [63:0] align_pc(input logic [63:0] pc, input int step);
      return pc & ~(64'(step) - 64'd1);
   endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundle of the fetch stage's memory, redirect and decode-side signals
// master (fetch_unit): drives imem_en/imem_addr and out_valid/out_inst/out_pc;
//                      receives imem_data, redirect_valid/redirect_pc and out_ready
// slave (memory/decode side): the mirror image
interface fetch_unit_if #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
);
   logic            imem_en;
   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [ILEN-1:0] out_inst;
   logic [XLEN-1:0] out_pc;

   modport master (
      output imem_en, imem_addr, out_valid, out_inst, out_pc,
      input  imem_data, redirect_valid, redirect_pc, out_ready
   );
   modport slave (
      input  imem_en, imem_addr, out_valid, out_inst, out_pc,
      output imem_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch entries; flush wins over push and pop
// Ports: clk, reset (async active-low), push/push_data, pop, flush,
//        head (oldest entry), count, full, empty
module fetch_queue
   import fetch_pkg::*;
#(
   parameter type T     = fetch_entry_t,
   parameter int  DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  T                           push_data,
   output T                           head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   T               mem_q [DEPTH];
   logic [AW-1:0]  rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   always_comb begin
      rd_d  = flush ? '0 : rd_q + AW'(pop);
      wr_d  = flush ? '0 : wr_q + AW'(push);
      cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_q] <= push_data;
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;
   assign full  = cnt_q == CW'(DEPTH);
   assign empty = cnt_q == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning the PC, a one-cycle-latency imem and an output queue
// Ports: clk, reset (async active-low),
//        bus (fetch_unit_if.master: imem read port, redirect request, valid/ready output of {pc, inst})
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = DEF_XLEN,
   parameter int              ILEN     = DEF_ILEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
   parameter int              PC_STEP  = DEF_PC_STEP,
   parameter int              IQ_DEPTH = 4
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   localparam int CW = $clog2(IQ_DEPTH + 1);
   localparam int NW = CW + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } entry_t;

   logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
   logic            inflight_q, inflight_d;
   logic            issue, push, pop, full, empty;
   logic [CW-1:0]   count;
   logic [NW-1:0]   need;
   entry_t          head, push_entry;

   always_comb begin
      pop = ~empty & bus.out_ready;
      // slots still claimed after this cycle's pop: queued plus the response in flight
      need = NW'(count) + NW'(inflight_q) - NW'(pop);
      issue = reset & ~bus.redirect_valid & (need < NW'(IQ_DEPTH));
      // the response landing on a redirect edge is dropped along with the flushed queue
      push = inflight_q & ~bus.redirect_valid;
      push_entry.pc = inflight_pc_q;
      push_entry.inst = bus.imem_data;
      pc_d = bus.redirect_valid ? XLEN'(align_pc(64'(bus.redirect_pc), PC_STEP))
           : issue ? pc_q + XLEN'(PC_STEP) : pc_q;
      inflight_d = issue;
      inflight_pc_d = issue ? pc_q : inflight_pc_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_queue #(
      .T     (entry_t),
      .DEPTH (IQ_DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (bus.redirect_valid),
      .push_data (push_entry),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign bus.imem_en   = issue;
   assign bus.imem_addr = pc_q;
   assign bus.out_valid = ~empty;
   assign bus.out_pc    = empty ? '0 : head.pc;
   assign bus.out_inst  = empty ? '0 : head.inst;

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit (flow, stall, redirects, wrap, async reset)
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_addr = '0;

   fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();
   fetch_unit_if #(.XLEN(8),  .ILEN(32)) wb ();

   fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0), .PC_STEP(4), .IQ_DEPTH(4))
      dut (.clk(clk), .reset(reset), .bus(bus));
   fetch_unit #(.XLEN(8), .ILEN(32), .RESET_PC(8'hF8), .PC_STEP(4), .IQ_DEPTH(4))
      dut_w (.clk(clk), .reset(reset), .bus(wb));

   always #5 clk = ~clk;

   // memory returns the address as data; idle cycles return junk that must never be captured
   always @(posedge clk) begin
      bus.imem_data <= bus.imem_en ? bus.imem_addr : 32'hDEAD_BEEF;
      wb.imem_data  <= wb.imem_en ? {24'h0, wb.imem_addr} : 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_check();
      logic [31:0] e;
      if (bus.out_valid) begin
         e = (sb.size() != 0) ? sb[0] : 32'hFFFF_FFFF;
         chk("out_pc", 64'(bus.out_pc), 64'(e));
         chk("out_inst", 64'(bus.out_inst), 64'(e));
         if (bus.out_ready && sb.size() != 0) void'(sb.pop_front());
      end
   endtask

   task automatic probe(input logic een, input int ev);
      chk("imem_en", 64'(bus.imem_en), 64'(een));
      if (een) begin
         chk("imem_addr", 64'(bus.imem_addr), 64'(exp_addr));
         sb.push_back(exp_addr);
         exp_addr += 32'd4;
      end
      if (ev >= 0) chk("out_valid", 64'(bus.out_valid), 64'(ev));
      if (ev == 0) begin
         chk("out_pc_idle", 64'(bus.out_pc), 64'd0);
         chk("out_inst_idle", 64'(bus.out_inst), 64'd0);
      end
      sb_check();
   endtask

   task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic een, input int ev);
      @(posedge clk);
      #1;
      bus.out_ready = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc = rpc;
      #1;
      probe(een, ev);
      if (rv) begin
         sb.delete();
         exp_addr = rpc & ~32'h3;
      end
   endtask

   task automatic wchk(input int c);
      logic [7:0] a;
      if (c < 4) begin
         a = 8'hF8 + 8'(4 * c);
         chk("wrap_addr", 64'(wb.imem_addr), 64'(a));
      end
      if (c >= 2 && c < 6) begin
         a = 8'hF8 + 8'(4 * (c - 2));
         chk("wrap_valid", 64'(wb.out_valid), 64'd1);
         chk("wrap_pc", 64'(wb.out_pc), 64'(a));
         chk("wrap_inst", 64'(wb.out_inst), 64'(a));
      end
   endtask

   initial begin
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      wb.out_ready = 1'b1;
      wb.redirect_valid = 1'b0;
      wb.redirect_pc = '0;
      #2;
      probe(1'b0, 0);
      chk("wrap_rst_en", 64'(wb.imem_en), 64'd0);
      // flow with out_ready high: one instruction per cycle after 2 cycles
      @(negedge clk);
      reset = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      probe(1'b1, 0);
      wchk(0);
      for (int c = 1; c < 8; c++) begin
         step(1'b1, 1'b0, 32'h0, 1'b1, (c < 2) ? 0 : 1);
         wchk(c);
      end
      // fill to 3 queued entries, then pulse reset asynchronously mid-cycle
      step(1'b0, 1'b0, 32'h0, 1'b1, 1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1);
      #1;
      reset = 1'b0;
      #1;
      probe(1'b0, 0);
      sb.delete();
      exp_addr = '0;
      // restart with out_ready low: exactly four requests, then stall
      @(negedge clk);
      reset = 1'b1;
      #1;
      probe(1'b1, 0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1);
      // release: request to 0x10 in the same cycle as the first pop
      step(1'b1, 1'b0, 32'h0, 1'b1, 1);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1);
      // redirect coincident with popping head 0x8
      step(1'b1, 1'b1, 32'h200, 1'b0, 1);
      step(1'b1, 1'b0, 32'h0, 1'b1, 0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 0);
      // stall so two entries are queued with one in flight, then redirect to an unaligned PC
      step(1'b0, 1'b0, 32'h0, 1'b1, 1);
      step(1'b0, 1'b1, 32'h103, 1'b0, 1);
      step(1'b1, 1'b0, 32'h0, 1'b1, 0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 0);
      for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 32'h0, 1'b1, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage that replaces the free-running PC-plus-4 fetcher. It owns the program counter and drives a synchronous instruction memory with fixed one-cycle read latency. Fetched instructions are buffered with their PCs in a small queue and handed to decode over a valid/ready handshake. It supports back-pressure, a branch/jump redirect with queue flush, and squashing of the in-flight memory read.

## Interface
- XLEN, 32, PC/address width (≥ 8)
- ILEN, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, sequential PC increment in bytes (power of 2)
- IQ_DEPTH, 4, instruction-queue entries (power of 2, ≥ 2)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_en  out  1  read strobe; data returns on imem_data exactly one cycle later
- imem_addr  out  XLEN  read address, valid when imem_en=1
- imem_data  in  ILEN  read data for the request issued in the previous cycle
- redirect_valid  in  1  one-cycle pulse: discard all fetched/in-flight work and restart at redirect_pc
- redirect_pc  in  XLEN  new fetch address; low log2(PC_STEP) bits are forced to 0
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head this cycle
- out_inst  out  ILEN  head instruction, 0 when out_valid=0
- out_pc  out  XLEN  head PC, 0 when out_valid=0

## Operation
- State: pc (next address to request), inflight flag plus inflight_pc, queue of {pc, inst} entries, occupancy count.
- Issue rule: imem_en=1 when reset is deasserted, redirect_valid=0, and occ + inflight − pop < IQ_DEPTH, where pop = out_valid & out_ready. imem_addr=pc. On issue: pc ← pc + PC_STEP (wraps modulo 2^XLEN), inflight ← 1, inflight_pc ← pc. Otherwise inflight ← 0.
- Capture: if inflight=1 and not squashed, push {inflight_pc, imem_data} into the queue at the same edge.
- Pop: out_valid & out_ready removes the head at the edge. Push and pop in the same cycle leave occupancy unchanged. Occupancy never exceeds IQ_DEPTH by construction. A push into a full queue is a design error and must be asserted against.
- Redirect: on the edge where redirect_valid=1, the queue is emptied, any in-flight response arriving next cycle is squashed, pc ← aligned redirect_pc, and no request is issued that cycle. A pop coincident with redirect counts as accepted.
- Back-pressure: out_ready=0 holds the head stable (out_inst and out_pc unchanged) until accepted or redirected.

## Timing
- Reset (reset=0, asynchronous): pc=RESET_PC, imem_en=0, inflight=0, queue empty, out_valid=0, out_inst=0, out_pc=0.
- First rising edge after reset release: imem_en=1 with imem_addr=RESET_PC, driven combinationally during cycle 0.
- Fetch-to-out latency: 2 cycles. Request in cycle N, entry pushed at end of N+1, out_valid=1 in N+2.
- Throughput: one instruction per cycle sustained with out_ready held high. Bubble-free with IQ_DEPTH ≥ 2.
- Redirect in cycle R: no request in R. First request to the new PC is issued in R+1. First redirected instruction appears at out in R+3. out_valid=0 in R+1 and R+2.
- Stall with out_ready=0: requests continue until occ + inflight = IQ_DEPTH, then imem_en=0. After out_ready rises, a request is reissued in the same cycle as the pop.
- Reset asserted mid-operation: immediate return to reset values; pending response ignored.

## Structure
- Package fetch_pkg: default constants RESET_PC and PC_STEP; typedef fetch_entry_t {pc[XLEN], inst[ILEN]}; helper for aligning a PC to PC_STEP.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, count, and full/empty flags. Flush has priority over push and pop. Same clk/reset as the parent.
- Parent holds the PC, inflight tracking and issue logic.

## Test plan
- Reset release, out_ready=1, memory returns addr as data: imem_addr 0,4,8,…; out_pc=0 with out_inst=0 in cycle 2, then one per cycle, all consecutive.
- out_ready=0 from cycle 0, IQ_DEPTH=4: exactly 4 requests (0,4,8,C), then imem_en=0. out_pc stays 0. Release out_ready: pops 0,4,8,C with the next request to 0x10 issued on the first pop.
- Redirect to 0x103 while queue holds 2 entries with one in flight: out_valid=0 for 2 cycles, stale response dropped, next out_pc=0x100, following 0x104.
- Redirect coincident with pop of head 0x8: pop accepted, no further stale entries, restart at target.
- PC wrap, XLEN=8, RESET_PC=0xF8: addresses F8, FC, 00, 04 with matching out_pc.
- Async reset pulse mid-stream with the queue at 3 entries: outputs zero immediately, fetch restarts at RESET_PC, no stale entry ever reaches out.
